cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL use one clock and a synchronous active-high reset; ports are named clock and reset.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 req_valid  input  4  per-unit completion request; bit 0 int ALU, bit 1 mult, bit 2 div, bit 3 load/store.
REQ-005 req_tag  input  20  packed ROB tags, 5 bits per unit; unit i uses bits [5i+4:5i].
REQ-006 req_data  input  128  packed result data, 32 bits per unit; unit i uses bits [32i+31:32i].
REQ-007 req_branch  input  4  per-unit flag: result is a branch resolution.
REQ-008 req_branch_taken  input  4  per-unit branch outcome; meaningful only when req_branch is set.
REQ-009 flush  input  1  mispredict flush; cancels the current arbitration cycle.
REQ-010 grant  output  4  one-hot combinational grant for the current cycle.
REQ-011 Cdb_rd_tag  output  5  registered broadcast tag.
REQ-012 Cdb_data  output  32  registered broadcast data.
REQ-013 Cdb_valid  output  1  registered broadcast valid.
REQ-014 Cdb_branch  output  1  registered branch flag.
REQ-015 Cdb_branch_taken  output  1  registered branch outcome.
REQ-016 Cdb_source  output  2  registered index of the unit that owns the current broadcast.

Function
REQ-017 SHALL assert at most one grant bit per cycle, and only for a unit with req_valid=1.
REQ-018 SHALL assert grant=0 when flush=1, when reset=1, or when req_valid=0.
REQ-019 Handshake: a requester SHALL hold tag, data and branch fields stable while req_valid=1 and grant is low for it. The request is consumed at the rising edge where its grant bit=1. The requester deasserts or presents its next result in the following cycle.
REQ-020 Latency: a grant in cycle N SHALL drive the Cdb_* outputs, with the winner's fields, in cycle N+1. Cdb_valid=1 lasts exactly one cycle per grant.
REQ-021 Cycles with no grant SHALL drive Cdb_valid=0 in the next cycle. Cdb_rd_tag, Cdb_data, Cdb_branch, Cdb_branch_taken and Cdb_source SHALL hold their last values.
REQ-022 Cdb_branch_taken SHALL be forced to 0 whenever Cdb_branch=0.
REQ-023 Priority pointer ptr (2 bits, wraps 3->0): the search order is ptr, ptr+1, ptr+2, ptr+3 mod 4. The first requester found wins.
REQ-024 After a grant to unit i, ptr SHALL become (i+1) mod 4. With no grant, ptr SHALL be unchanged.
REQ-025 flush SHALL leave ptr unchanged. The cycle after a flush SHALL have Cdb_valid=0. Pending requests are re-arbitrated only if they are still asserted after the flush.
REQ-026 Starvation bound: with round-robin enabled, a continuously asserted request SHALL be granted within 4 non-flush cycles.

Reset
REQ-027 When reset=1 at a rising edge, the block SHALL load:
- ptr=0, Cdb_valid=0, Cdb_rd_tag=0, Cdb_data=0;
- Cdb_branch=0, Cdb_branch_taken=0, Cdb_source=0.
REQ-028 A reset asserted mid-operation SHALL discard any grant in that cycle; no broadcast follows the reset cycle.

Configuration
REQ-029 Macro CDB_ROUND_ROBIN_EN defined: arbitration SHALL follow REQ-023/REQ-024.
REQ-030 Macro CDB_ROUND_ROBIN_EN undefined: arbitration SHALL be fixed priority, unit 0 highest and unit 3 lowest. ptr is not implemented and REQ-026 does not apply.

Verification
REQ-031 Reset, then idle -> Cdb_valid=0 and all Cdb_* outputs 0 for 5 cycles.
REQ-032 Unit 1 alone, tag=7, data=0x1234 in cycle N -> grant=4'b0010 in N; Cdb_valid=1, Cdb_rd_tag=7, Cdb_data=0x1234, Cdb_source=1 in N+1.
REQ-033 All four units request continuously, round-robin enabled, after reset -> grants 0,1,2,3,0 on consecutive cycles. Without the macro -> unit 0 is granted every cycle.
REQ-034 Unit 3 branch with taken=1, tag=20 -> next cycle Cdb_branch=1, Cdb_branch_taken=1, Cdb_rd_tag=20. Same with req_branch=0, taken=1 -> Cdb_branch_taken=0.
REQ-035 Units 0 and 2 request, flush=1 in that cycle -> grant=0, Cdb_valid=0 next cycle, ptr unchanged. With flush=0 on the next cycle, unit 0 is granted.
REQ-036 Grant to unit 2 in the same cycle that reset=1 -> no broadcast next cycle, ptr=0.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: picks one of four functional-unit completions per cycle and
// broadcasts the winner's tag/data/branch result on the common data bus one
// cycle later.
//
// Configuration macro: CDB_ROUND_ROBIN_EN
//   defined   -> rotating priority pointer; search order starts at ptr and
//                ptr moves just past the last winner.
//   undefined -> fixed priority, unit 0 highest, unit 3 lowest.
module cdb_arbiter (
  input  logic         clock,
  input  logic         reset,
  input  logic [3:0]   req_valid,
  input  logic [19:0]  req_tag,
  input  logic [127:0] req_data,
  input  logic [3:0]   req_branch,
  input  logic [3:0]   req_branch_taken,
  input  logic         flush,
  output logic [3:0]   grant,
  output logic [4:0]   Cdb_rd_tag,
  output logic [31:0]  Cdb_data,
  output logic         Cdb_valid,
  output logic         Cdb_branch,
  output logic         Cdb_branch_taken,
  output logic [1:0]   Cdb_source
);

  // Arbitration result for the current cycle.
  logic       win_found;
  logic [1:0] win_idx;
  logic [1:0] cand;

  // Winner's request fields, selected by win_idx.
  logic [4:0]  sel_tag;
  logic [31:0] sel_data;
  logic        sel_branch;
  logic        sel_taken;

  // Broadcast registers and their next-state values.
  logic        valid_q,  valid_d;
  logic [4:0]  tag_q,    tag_d;
  logic [31:0] data_q,   data_d;
  logic        branch_q, branch_d;
  logic        taken_q,  taken_d;
  logic [1:0]  source_q, source_d;

`ifdef CDB_ROUND_ROBIN_EN
  logic [1:0] ptr_q, ptr_d;
`endif

  // Search the requesters in priority order; flush and reset suppress any winner.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    win_found = 1'b0;
    win_idx   = 2'd0;
    cand      = 2'd0;
    if (!reset && !flush) begin
      for (int k = 0; k < 4; k++) begin
`ifdef CDB_ROUND_ROBIN_EN
        cand = ptr_q + 2'(k);
`else
        cand = 2'(k);
`endif
        if (!win_found && req_valid[cand]) begin
          win_found = 1'b1;
          win_idx   = cand;
        end
      end
    end
  end

  assign grant = win_found ? (4'b0001 << win_idx) : 4'b0000;

  // Route the winning unit's fields toward the broadcast registers.
  always_comb begin
    sel_tag    = req_tag[4:0];
    sel_data   = req_data[31:0];
    sel_branch = req_branch[0];
    sel_taken  = req_branch_taken[0];
    case (win_idx)
      2'd1: begin
        sel_tag    = req_tag[9:5];
        sel_data   = req_data[63:32];
        sel_branch = req_branch[1];
        sel_taken  = req_branch_taken[1];
      end
      2'd2: begin
        sel_tag    = req_tag[14:10];
        sel_data   = req_data[95:64];
        sel_branch = req_branch[2];
        sel_taken  = req_branch_taken[2];
      end
      2'd3: begin
        sel_tag    = req_tag[19:15];
        sel_data   = req_data[127:96];
        sel_branch = req_branch[3];
        sel_taken  = req_branch_taken[3];
      end
      default: ;
    endcase
  end

  // Load the broadcast on a grant; otherwise drop valid and hold the payload.
  always_comb begin
    valid_d  = 1'b0;
    tag_d    = tag_q;
    data_d   = data_q;
    branch_d = branch_q;
    taken_d  = taken_q;
    source_d = source_q;
    if (win_found) begin
      valid_d  = 1'b1;
      tag_d    = sel_tag;
      data_d   = sel_data;
      branch_d = sel_branch;
      // A taken flag without a branch is meaningless, so it never reaches the bus.
      taken_d  = sel_branch & sel_taken;
      source_d = win_idx;
    end
  end

  // Broadcast register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
      valid_q  <= 1'b0;
      tag_q    <= '0;
      data_q   <= '0;
      branch_q <= 1'b0;
      taken_q  <= 1'b0;
      source_q <= '0;
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      data_q   <= data_d;
      branch_q <= branch_d;
      taken_q  <= taken_d;
      source_q <= source_d;
    end
  end

`ifdef CDB_ROUND_ROBIN_EN
  // Pointer moves just past the winner; idle and flushed cycles leave it alone.
  always_comb begin
    ptr_d = win_found ? (win_idx + 2'd1) : ptr_q;
  end

  // Priority pointer register.
  always_ff @(posedge clock) begin
    if (reset) ptr_q <= 2'd0;
    else       ptr_q <= ptr_d;
  end
`endif

  assign Cdb_valid        = valid_q;
  assign Cdb_rd_tag       = tag_q;
  assign Cdb_data         = data_q;
  assign Cdb_branch       = branch_q;
  assign Cdb_branch_taken = taken_q;
  assign Cdb_source       = source_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter. Expected grants and bus contents come
// from a behavioural model that applies the arbitration rules directly.
// Honours CDB_ROUND_ROBIN_EN the same way the design does.
module tb_cdb_arbiter;

  logic         clock = 1'b0;
  logic         reset;
  logic [3:0]   req_valid;
  logic [19:0]  req_tag;
  logic [127:0] req_data;
  logic [3:0]   req_branch;
  logic [3:0]   req_branch_taken;
  logic         flush;
  logic [3:0]   grant;
  logic [4:0]   Cdb_rd_tag;
  logic [31:0]  Cdb_data;
  logic         Cdb_valid;
  logic         Cdb_branch;
  logic         Cdb_branch_taken;
  logic [1:0]   Cdb_source;

  cdb_arbiter dut (
    .clock            (clock),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_tag          (req_tag),
    .req_data         (req_data),
    .req_branch       (req_branch),
    .req_branch_taken (req_branch_taken),
    .flush            (flush),
    .grant            (grant),
    .Cdb_rd_tag       (Cdb_rd_tag),
    .Cdb_data         (Cdb_data),
    .Cdb_valid        (Cdb_valid),
    .Cdb_branch       (Cdb_branch),
    .Cdb_branch_taken (Cdb_branch_taken),
    .Cdb_source       (Cdb_source)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state.
  int          m_ptr = 0;
  logic        e_valid, e_branch, e_taken;
  logic [4:0]  e_tag;
  logic [31:0] e_data;
  logic [1:0]  e_src;

  logic [41:0] dut_bus;
  assign dut_bus = {Cdb_valid, Cdb_rd_tag, Cdb_data, Cdb_branch, Cdb_branch_taken, Cdb_source};

  function automatic logic [41:0] exp_bus();
    return {e_valid, e_tag, e_data, e_branch, e_taken, e_src};
  endfunction

  // Winner under the current inputs, or -1 when nobody is granted.
  function automatic int model_winner();
    int u;
    if (reset || flush) return -1;
    for (int k = 0; k < 4; k++) begin
`ifdef CDB_ROUND_ROBIN_EN
      u = (m_ptr + k) % 4;
`else
      u = k;
`endif
      if (req_valid[u]) return u;
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_grant();
    int w;
    w = model_winner();
    return (w < 0) ? 4'b0000 : 4'(1 << w);
  endfunction

  // What the rising edge does to the model.
  task automatic model_clock();
    int w;
    w = model_winner();
    if (reset) begin
      e_valid = 0; e_tag = 0; e_data = 0; e_branch = 0; e_taken = 0; e_src = 0;
      m_ptr = 0;
    end else if (w >= 0) begin
      e_valid  = 1;
      e_tag    = req_tag[5*w +: 5];
      e_data   = req_data[32*w +: 32];
      e_branch = req_branch[w];
      e_taken  = req_branch[w] && req_branch_taken[w];
      e_src    = 2'(w);
      m_ptr    = (w + 1) % 4;
    end else begin
      e_valid = 0;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_clock();
    #1;
  endtask

  task automatic clear_inputs();
    req_valid = 0; req_tag = 0; req_data = 0;
    req_branch = 0; req_branch_taken = 0; flush = 0; reset = 0;
  endtask

  task automatic set_req(input int u, input logic [4:0] tag, input logic [31:0] data,
                         input logic br, input logic tk);
    req_valid[u]        = 1'b1;
    req_tag[5*u +: 5]   = tag;
    req_data[32*u +: 32] = data;
    req_branch[u]       = br;
    req_branch_taken[u] = tk;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (dut_bus !== 42'd0 || grant !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: bus=%h grant=%b, required bus=0 grant=0", i, dut_bus, grant);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    set_req(1, 5'd7, 32'h1234, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (grant !== 4'b0010) begin
      n_fail++;
      $display("FAIL single_grant: got %b, required 0010", grant);
    end
    tick();
    clear_inputs();
    n_checks++;
    if (Cdb_valid !== 1'b1 || Cdb_rd_tag !== 5'd7 || Cdb_data !== 32'h1234 || Cdb_source !== 2'd1) begin
      n_fail++;
      $display("FAIL single_bus: valid=%b tag=%0d data=%h src=%0d, required 1/7/1234/1",
               Cdb_valid, Cdb_rd_tag, Cdb_data, Cdb_source);
    end
    tick();
    n_checks++;
    if (Cdb_valid !== 1'b0 || Cdb_rd_tag !== 5'd7 || Cdb_data !== 32'h1234) begin
      n_fail++;
      $display("FAIL single_hold: valid=%b tag=%0d data=%h, required 0/7/1234", Cdb_valid, Cdb_rd_tag, Cdb_data);
    end
  endtask

  task automatic test_all_request();
    logic [3:0] want;
    do_reset();
    for (int u = 0; u < 4; u++) set_req(u, 5'(u + 10), 32'hA000 + u, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
`ifdef CDB_ROUND_ROBIN_EN
      want = 4'(1 << (i % 4));
`else
      want = 4'b0001;
`endif
      n_checks++;
      if (grant !== want) begin
        n_fail++;
        $display("FAIL all_request cycle %0d: grant=%b, required %b", i, grant, want);
      end
      tick();
      n_checks++;
      if (dut_bus !== exp_bus()) begin
        n_fail++;
        $display("FAIL all_request_bus cycle %0d: got %h, required %h", i, dut_bus, exp_bus());
      end
    end
    clear_inputs();
  endtask

  task automatic test_branch();
    do_reset();
    set_req(3, 5'd20, 32'hBEEF, 1'b1, 1'b1);
    #1;
    n_checks++;
    if (grant !== 4'b1000) begin
      n_fail++;
      $display("FAIL branch_grant: got %b, required 1000", grant);
    end
    tick();
    n_checks++;
    if (Cdb_branch !== 1'b1 || Cdb_branch_taken !== 1'b1 || Cdb_rd_tag !== 5'd20 || Cdb_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL branch_taken: br=%b tk=%b tag=%0d valid=%b, required 1/1/20/1",
               Cdb_branch, Cdb_branch_taken, Cdb_rd_tag, Cdb_valid);
    end
    set_req(3, 5'd21, 32'hCAFE, 1'b0, 1'b1);
    tick();
    n_checks++;
    if (Cdb_branch !== 1'b0 || Cdb_branch_taken !== 1'b0 || Cdb_rd_tag !== 5'd21) begin
      n_fail++;
      $display("FAIL branch_masked: br=%b tk=%b tag=%0d, required 0/0/21", Cdb_branch, Cdb_branch_taken, Cdb_rd_tag);
    end
    clear_inputs();
  endtask

  task automatic test_flush();
    do_reset();
    // Move the pointer off zero first (round-robin build), then flush a 0+2 request.
    set_req(0, 5'd1, 32'h11, 1'b0, 1'b0);
    tick();
    clear_inputs();
    set_req(0, 5'd2, 32'h22, 1'b0, 1'b0);
    set_req(2, 5'd3, 32'h33, 1'b0, 1'b0);
    flush = 1;
    #1;
    n_checks++;
    if (grant !== 4'b0000) begin
      n_fail++;
      $display("FAIL flush_grant: got %b, required 0000", grant);
    end
    tick();
    flush = 0;
    n_checks++;
    if (Cdb_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_valid: got %b, required 0", Cdb_valid);
    end
    #1;
    n_checks++;
    if (grant !== model_grant()) begin
      n_fail++;
      $display("FAIL flush_regrant: got %b, required %b", grant, model_grant());
    end
    tick();
    n_checks++;
    if (dut_bus !== exp_bus()) begin
      n_fail++;
      $display("FAIL flush_bus: got %h, required %h", dut_bus, exp_bus());
    end
    // Same scenario straight after reset: unit 0 wins once flush drops.
    do_reset();
    set_req(0, 5'd4, 32'h44, 1'b0, 1'b0);
    set_req(2, 5'd5, 32'h55, 1'b0, 1'b0);
    flush = 1;
    tick();
    flush = 0;
    #1;
    n_checks++;
    if (grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL flush_after_reset: grant=%b, required 0001", grant);
    end
    clear_inputs();
  endtask

  task automatic test_reset_midop();
    do_reset();
    set_req(2, 5'd9, 32'h99, 1'b0, 1'b0);
    tick();
    set_req(2, 5'd12, 32'h1200, 1'b1, 1'b1);
    reset = 1;
    #1;
    n_checks++;
    if (grant !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_midop_grant: got %b, required 0000", grant);
    end
    tick();
    clear_inputs();
    n_checks++;
    if (dut_bus !== 42'd0) begin
      n_fail++;
      $display("FAIL reset_midop_bus: got %h, required 0", dut_bus);
    end
    for (int u = 0; u < 4; u++) set_req(u, 5'(u), 32'(u), 1'b0, 1'b0);
    #1;
    n_checks++;
    if (grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_midop_ptr: grant=%b, required 0001", grant);
    end
    clear_inputs();
  endtask

  task automatic test_random();
    int w;
    int wait_cnt [4];
    logic quiet;
    do_reset();
    for (int u = 0; u < 4; u++) wait_cnt[u] = 0;
    for (int i = 0; i < 400; i++) begin
      for (int u = 0; u < 4; u++)
        if (!req_valid[u] && $urandom_range(1) == 1)
          set_req(u, 5'($urandom), $urandom, 1'($urandom), 1'($urandom));
      flush = ($urandom_range(9) == 0);
      reset = ($urandom_range(39) == 0);
      #1;
      w = model_winner();
      quiet = reset || flush;
      n_checks++;
      if (grant !== model_grant()) begin
        n_fail++;
        $display("FAIL random_grant cycle %0d: got %b, required %b", i, grant, model_grant());
      end
`ifdef CDB_ROUND_ROBIN_EN
      if (w >= 0) begin
        n_checks++;
        if (wait_cnt[w] >= 4) begin
          n_fail++;
          $display("FAIL starvation unit %0d: waited %0d cycles, required under 4", w, wait_cnt[w]);
        end
      end
`endif
      tick();
      n_checks++;
      if (dut_bus !== exp_bus()) begin
        n_fail++;
        $display("FAIL random_bus cycle %0d: got %h, required %h", i, dut_bus, exp_bus());
      end
      for (int u = 0; u < 4; u++) begin
        if (u == w) begin
          req_valid[u] = 1'b0;
          wait_cnt[u]  = 0;
        end else if (req_valid[u] && !quiet) begin
          wait_cnt[u]++;
        end
      end
      flush = 0;
      reset = 0;
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    test_reset();
    test_single();
    test_all_request();
    test_branch();
    test_flush();
    test_reset_midop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
